// File: rtl/id_stage_pipe.sv
// MIPS decode stage: forwarding, load-use stall, branch redirect; ID_FWD_MEM_EN enables MEM forwarding.
// Output bundle registered (1 cycle); in_ready drops and outputs hold while ex_ready is low.
module id_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int LOAD_STALL = 1,
    parameter int AOPW       = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_pc,
    input  logic [31:0]     in_inst,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            exe_we,
    input  logic [4:0]      exe_wreg,
    input  logic [XLEN-1:0] exe_wdata,
    input  logic            exe_is_load,
    input  logic            mem_we,
    input  logic [4:0]      mem_wreg,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [AOPW-1:0] ex_aluop,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_sdata,
    output logic [4:0]      ex_wreg,
    output logic            ex_we,
    output logic            br_taken,
    output logic [31:0]     br_target
);

`ifdef ID_FWD_MEM_EN
    localparam bit MEM_FWD = 1'b1;
`else
    localparam bit MEM_FWD = 1'b0;
`endif

    localparam logic [AOPW-1:0] ALU_NOP = AOPW'(0),  ALU_ADD = AOPW'(1),  ALU_SUB = AOPW'(2);
    localparam logic [AOPW-1:0] ALU_SLT = AOPW'(3),  ALU_SLTU = AOPW'(4), ALU_AND = AOPW'(5);
    localparam logic [AOPW-1:0] ALU_OR  = AOPW'(6),  ALU_XOR = AOPW'(7),  ALU_NOR = AOPW'(8);
    localparam logic [AOPW-1:0] ALU_SLL = AOPW'(9),  ALU_SRL = AOPW'(10), ALU_SRA = AOPW'(11);
    localparam logic [AOPW-1:0] ALU_LW  = AOPW'(12), ALU_SW = AOPW'(13);

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] pc4, pc8, br_off;
    assign opcode = in_inst[31:26];
    assign rs     = in_inst[25:21];
    assign rt     = in_inst[20:16];
    assign rd     = in_inst[15:11];
    assign shamt  = in_inst[10:6];
    assign funct  = in_inst[5:0];
    assign imm    = in_inst[15:0];
    assign pc4    = in_pc + 32'd4;
    assign pc8    = in_pc + 32'd8;
    assign br_off = {{14{imm[15]}}, imm, 2'b00};
    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    // Source select: EXE, then MEM (when enabled), then RF; $0 is hard zero.
    logic rs_exe_hit, rt_exe_hit, rs_mem_hit, rt_mem_hit;
    logic [XLEN-1:0] rs_val, rt_val;
    assign rs_exe_hit = exe_we && (exe_wreg == rs) && (rs != 5'd0);
    assign rt_exe_hit = exe_we && (exe_wreg == rt) && (rt != 5'd0);
    assign rs_mem_hit = mem_we && (mem_wreg == rs) && (rs != 5'd0);
    assign rt_mem_hit = mem_we && (mem_wreg == rt) && (rt != 5'd0);
    assign rs_val = (rs == 5'd0) ? '0 : rs_exe_hit ? exe_wdata :
                    (MEM_FWD && rs_mem_hit) ? mem_wdata : rf_rdata1;
    assign rt_val = (rt == 5'd0) ? '0 : rt_exe_hit ? exe_wdata :
                    (MEM_FWD && rt_mem_hit) ? mem_wdata : rf_rdata2;

    logic [AOPW-1:0] d_aluop;
    logic [XLEN-1:0] d_op1, d_op2;
    logic [4:0]      d_wreg;
    logic            d_we, use_rs, use_rt, d_take, r_alu, i_alu;
    logic [31:0]     d_target;

    always_comb begin
        d_aluop  = ALU_NOP;
        d_op1    = rs_val;
        d_op2    = rt_val;
        d_wreg   = 5'd0;
        d_we     = 1'b0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        d_take   = 1'b0;
        r_alu    = 1'b0;
        i_alu    = 1'b0;
        d_target = pc4 + br_off;
        case (opcode)
            6'b000000: case (funct)
                6'b100000, 6'b100001: begin d_aluop = ALU_ADD;  r_alu = 1'b1; end
                6'b100010, 6'b100011: begin d_aluop = ALU_SUB;  r_alu = 1'b1; end
                6'b101010: begin d_aluop = ALU_SLT;  r_alu = 1'b1; end
                6'b101011: begin d_aluop = ALU_SLTU; r_alu = 1'b1; end
                6'b100100: begin d_aluop = ALU_AND;  r_alu = 1'b1; end
                6'b100101: begin d_aluop = ALU_OR;   r_alu = 1'b1; end
                6'b100110: begin d_aluop = ALU_XOR;  r_alu = 1'b1; end
                6'b100111: begin d_aluop = ALU_NOR;  r_alu = 1'b1; end
                6'b000100: begin d_aluop = ALU_SLL;  r_alu = 1'b1; end
                6'b000110: begin d_aluop = ALU_SRL;  r_alu = 1'b1; end
                6'b000111: begin d_aluop = ALU_SRA;  r_alu = 1'b1; end
                // Shift-immediate: amount in op1, value in op2, like the variable forms.
                6'b000000, 6'b000010, 6'b000011: begin
                    d_aluop = (funct[1:0] == 2'b00) ? ALU_SLL :
                              (funct[1:0] == 2'b10) ? ALU_SRL : ALU_SRA;
                    d_op1   = XLEN'(shamt);
                    use_rt  = 1'b1;
                    d_we    = 1'b1;
                    d_wreg  = rd;
                end
                6'b001000, 6'b001001: begin
                    use_rs   = 1'b1;
                    d_take   = 1'b1;
                    d_target = rs_val[31:0];
                    if (funct[0]) begin
                        d_aluop = ALU_ADD;
                        d_op1   = XLEN'(pc8);
                        d_op2   = '0;
                        d_we    = 1'b1;
                        d_wreg  = rd;
                    end
                end
                default: ;
            endcase
            6'b000010, 6'b000011: begin
                d_take   = 1'b1;
                d_target = {pc4[31:28], in_inst[25:0], 2'b00};
                if (opcode[0]) begin
                    d_aluop = ALU_ADD;
                    d_op1   = XLEN'(pc8);
                    d_op2   = '0;
                    d_we    = 1'b1;
                    d_wreg  = 5'd31;
                end
            end
            6'b000100, 6'b000101: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                d_take = (rs_val == rt_val) ^ opcode[0];
            end
            6'b001000, 6'b001001: begin d_aluop = ALU_ADD;  d_op2 = XLEN'(signed'(imm)); i_alu = 1'b1; end
            6'b001010: begin d_aluop = ALU_SLT;  d_op2 = XLEN'(signed'(imm)); i_alu = 1'b1; end
            6'b001011: begin d_aluop = ALU_SLTU; d_op2 = XLEN'(signed'(imm)); i_alu = 1'b1; end
            6'b001100: begin d_aluop = ALU_AND;  d_op2 = XLEN'(imm); i_alu = 1'b1; end
            6'b001101: begin d_aluop = ALU_OR;   d_op2 = XLEN'(imm); i_alu = 1'b1; end
            6'b001110: begin d_aluop = ALU_XOR;  d_op2 = XLEN'(imm); i_alu = 1'b1; end
            6'b100011: begin d_aluop = ALU_LW;   d_op2 = XLEN'(signed'(imm)); i_alu = 1'b1; end
            6'b001111: begin
                d_aluop = ALU_ADD;
                d_op1   = '0;
                d_op2   = XLEN'(signed'({imm, 16'h0000}));
                d_we    = 1'b1;
                d_wreg  = rt;
            end
            6'b101011: begin
                d_aluop = ALU_SW;
                d_op2   = XLEN'(signed'(imm));
                use_rs  = 1'b1;
                use_rt  = 1'b1;
            end
            default: ;
        endcase
        if (r_alu) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
            d_we   = 1'b1;
            d_wreg = rd;
        end
        if (i_alu) begin
            use_rs = 1'b1;
            d_we   = 1'b1;
            d_wreg = rt;
        end
    end

    logic [1:0] cnt, cnt_eff;
    logic       src_rs, src_rt, load_haz, mem_haz, stall, slot_free, accept;
    assign src_rs   = use_rs && (rs != 5'd0);
    assign src_rt   = use_rt && (rt != 5'd0);
    assign load_haz = in_valid && exe_is_load &&
                      ((src_rs && exe_wreg == rs) || (src_rt && exe_wreg == rt));
    // Without MEM forwarding, a MEM-only match waits one bubble for the RF write-through.
    assign mem_haz  = !MEM_FWD && in_valid && mem_we &&
                      ((src_rs && mem_wreg == rs && !rs_exe_hit) ||
                       (src_rt && mem_wreg == rt && !rt_exe_hit));
    // The counter includes the detection cycle, so LOAD_STALL bubbles are issued in total.
    assign cnt_eff   = (cnt != 2'd0) ? cnt : (load_haz ? 2'(LOAD_STALL) : 2'd0);
    assign stall     = (cnt_eff != 2'd0) || mem_haz;
    assign slot_free = !ex_valid || ex_ready;
    assign in_ready  = !rst && !flush && !stall && slot_free;
    assign accept    = in_valid && in_ready;
    assign br_taken  = accept && d_take;
    assign br_target = d_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_aluop <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_sdata <= '0;
            ex_wreg  <= '0;
            ex_we    <= 1'b0;
            cnt      <= 2'd0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            cnt      <= 2'd0;
        end else begin
            cnt <= (cnt_eff != 2'd0 && slot_free) ? cnt_eff - 2'd1 : cnt_eff;
            if (accept) begin
                ex_valid <= 1'b1;
                ex_aluop <= d_aluop;
                ex_op1   <= d_op1;
                ex_op2   <= d_op2;
                ex_sdata <= rt_val;
                ex_wreg  <= d_wreg;
                ex_we    <= d_we;
            end else if (slot_free) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, forwarding, stalls, redirect, backpressure, flush.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [31:0] in_pc, in_inst;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        exe_we, exe_is_load, mem_we;
    logic [4:0]  exe_wreg, mem_wreg;
    logic [31:0] exe_wdata, mem_wdata;
    logic        flush, ex_ready, ex_valid, ex_we, br_taken;
    logic [5:0]  ex_aluop;
    logic [31:0] ex_op1, ex_op2, ex_sdata, br_target;
    logic [4:0]  ex_wreg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .exe_we(exe_we), .exe_wreg(exe_wreg), .exe_wdata(exe_wdata), .exe_is_load(exe_is_load),
        .mem_we(mem_we), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_sdata(ex_sdata), .ex_wreg(ex_wreg),
        .ex_we(ex_we), .br_taken(br_taken), .br_target(br_target)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h0C000100;
        rf_rdata1 = '0; rf_rdata2 = '0;
        exe_we = 1'b0; exe_wreg = '0; exe_wdata = '0; exe_is_load = 1'b0;
        mem_we = 1'b0; mem_wreg = '0; mem_wdata = '0;
        flush = 1'b0; ex_ready = 1'b1;
        tick();
        tick();
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_br_taken", 32'(br_taken), 0);
        check("rst_op1", ex_op1, 0);

        // addiu $1,$0,5 with a bogus EXE write to $0
        rst = 1'b0; in_inst = 32'h24010005;
        exe_we = 1'b1; exe_wreg = 5'd0; exe_wdata = 32'hDEAD; rf_rdata1 = 32'h55;
        #1 check("addiu_in_ready", 32'(in_ready), 1);
        tick();
        check("addiu_valid", 32'(ex_valid), 1);
        check("addiu_op1", ex_op1, 0);
        check("addiu_op2", ex_op2, 5);
        check("addiu_wreg", 32'(ex_wreg), 1);
        check("addiu_we", 32'(ex_we), 1);
        check("addiu_aluop", 32'(ex_aluop), 1);

        // addu $3,$1,$2: EXE beats MEM for $1
        in_inst = 32'h00221821; exe_wreg = 5'd1; exe_wdata = 32'd7;
        mem_we = 1'b1; mem_wreg = 5'd1; mem_wdata = 32'd9;
        rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
        tick();
        check("fwd_op1", ex_op1, 7);
        check("fwd_op2", ex_op2, 32'h22);
        check("fwd_wreg", 32'(ex_wreg), 3);

        // ori $2,$1,0x8000 zero-extends
        exe_we = 1'b0; mem_we = 1'b0; in_inst = 32'h34228000; rf_rdata1 = 32'h0F0F0000;
        tick();
        check("ori_op1", ex_op1, 32'h0F0F0000);
        check("ori_op2", ex_op2, 32'h00008000);
        check("ori_aluop", 32'(ex_aluop), 6);

        // lui $3,0x8001
        in_inst = 32'h3C038001;
        tick();
        check("lui_op1", ex_op1, 0);
        check("lui_op2", ex_op2, 32'h80010000);
        check("lui_wreg", 32'(ex_wreg), 3);

        // sll $4,$2,3
        in_inst = 32'h000220C0; rf_rdata2 = 32'hAB;
        tick();
        check("sll_op1", ex_op1, 3);
        check("sll_op2", ex_op2, 32'hAB);
        check("sll_aluop", 32'(ex_aluop), 9);

        // slti $1,$2,-1 sign-extends
        in_inst = 32'h2841FFFF;
        tick();
        check("slti_op2", ex_op2, 32'hFFFFFFFF);
        check("slti_aluop", 32'(ex_aluop), 3);

        // unknown opcode becomes a valid NOP
        in_inst = 32'hFC000000;
        tick();
        check("nop_valid", 32'(ex_valid), 1);
        check("nop_we", 32'(ex_we), 0);
        check("nop_aluop", 32'(ex_aluop), 0);

        // beq $1,$1,+3 at 0x100
        in_inst = 32'h10210003; rf_rdata1 = 32'h42; rf_rdata2 = 32'h42;
        #1;
        check("beq_taken", 32'(br_taken), 1);
        check("beq_target", br_target, 32'h110);
        tick();
        check("beq_we", 32'(ex_we), 0);

        // bne $1,$2 with equal values is not taken
        in_inst = 32'h14220003;
        #1 check("bne_not_taken", 32'(br_taken), 0);
        tick();

        // jal at 0x100
        in_inst = 32'h0C000100;
        #1;
        check("jal_taken", 32'(br_taken), 1);
        check("jal_target", br_target, 32'h400);
        tick();
        check("jal_op1", ex_op1, 32'h108);
        check("jal_op2", ex_op2, 0);
        check("jal_wreg", 32'(ex_wreg), 31);
        check("jal_we", 32'(ex_we), 1);

        // flush suppresses the redirect and the bundle
        flush = 1'b1;
        #1;
        check("flush_br_taken", 32'(br_taken), 0);
        check("flush_in_ready", 32'(in_ready), 0);
        tick();
        check("flush_ex_valid", 32'(ex_valid), 0);
        flush = 1'b0;

        // jr $31
        in_inst = 32'h03E00008; rf_rdata1 = 32'h2000;
        #1 check("jr_target", br_target, 32'h2000);
        tick();
        check("jr_we", 32'(ex_we), 0);

        // Backpressure: three cycles of ex_ready=0 hold the bundle
        in_inst = 32'h00221821; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
        tick();
        ex_ready = 1'b0; in_inst = 32'h24010005; rf_rdata1 = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", 32'(in_ready), 0);
            tick();
            check("bp_op1", ex_op1, 32'h11);
            check("bp_wreg", 32'(ex_wreg), 3);
            check("bp_valid", 32'(ex_valid), 1);
        end
        ex_ready = 1'b1;
        #1 check("bp_release", 32'(in_ready), 1);
        tick();
        check("bp_next_wreg", 32'(ex_wreg), 1);

        // Load-use: lw $4 in EXE, then addu $5,$4,$4
        in_inst = 32'h00842821; exe_is_load = 1'b1; exe_we = 1'b1; exe_wreg = 5'd4;
        exe_wdata = 32'hBAD; rf_rdata1 = 32'h33; rf_rdata2 = 32'h33;
        #1 check("lu_in_ready", 32'(in_ready), 0);
        tick();
        check("lu_bubble", 32'(ex_valid), 0);
        exe_is_load = 1'b0; exe_we = 1'b0;
        mem_we = 1'b1; mem_wreg = 5'd4; mem_wdata = 32'h77;
`ifdef ID_FWD_MEM_EN
        #1 check("lu_resume", 32'(in_ready), 1);
        tick();
`else
        #1 check("mem_stall", 32'(in_ready), 0);
        tick();
        check("mem_bubble", 32'(ex_valid), 0);
        mem_we = 1'b0; rf_rdata1 = 32'h77; rf_rdata2 = 32'h77;
        #1 check("lu_resume", 32'(in_ready), 1);
        tick();
`endif
        check("lu_op1", ex_op1, 32'h77);
        check("lu_op2", ex_op2, 32'h77);
        check("lu_valid", 32'(ex_valid), 1);

        // Flush during a pending load stall clears the counter
        mem_we = 1'b0; ex_ready = 1'b0;
        exe_is_load = 1'b1; exe_we = 1'b1; exe_wreg = 5'd4;
        #1 check("fls_in_ready", 32'(in_ready), 0);
        tick();
        check("fls_hold_valid", 32'(ex_valid), 1);
        exe_is_load = 1'b0; exe_we = 1'b0; flush = 1'b1;
        #1 check("fls_flush_ready", 32'(in_ready), 0);
        tick();
        check("fls_ex_valid", 32'(ex_valid), 0);
        flush = 1'b0; ex_ready = 1'b1; in_inst = 32'h24010005;
        #1 check("fls_cnt_cleared", 32'(in_ready), 1);
        tick();
        check("fls_after_valid", 32'(ex_valid), 1);
        check("fls_after_op2", ex_op2, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
